// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the six-stage pipeline, with fetch-response discard tracking.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int MAX_IF_OUTSTANDING = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inst_req,
    input  logic inst_addr_ok,
    input  logic inst_data_ok,
    input  logic if_valid,
    input  logic id_load_use,
    input  logic ex_busy,
    input  logic mm1_exc,
    input  logic mm1_ertn,
    input  logic mm2_mem_req,
    input  logic data_addr_ok,
    input  logic data_data_ok,
    output logic pc_wen,
    output logic wen_if_id,
    output logic wen_id_ex,
    output logic wen_ex_mm1,
    output logic wen_mm1_mm2,
    output logic wen_mm2_wb,
    output logic flush_if_id,
    output logic flush_id_ex,
    output logic flush_ex_mm1,
    output logic flush_mm1_mm2,
    output logic flush_mm2_wb,
    output logic redirect,
    output logic redirect_ertn,
    output logic inst_discard
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] perf_mem_stall,
    output logic [31:0] perf_ex_stall,
    output logic [31:0] perf_lu_stall,
    output logic [31:0] perf_redirect
`endif
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;
    localparam logic [1:0] IF_MAX   = 2'(MAX_IF_OUTSTANDING);

    logic [0:0] mem_st;
    logic [1:0] if_out;
    logic [1:0] if_out_nxt;
    logic [1:0] owed;
    logic [1:0] discard_cnt;
    logic       fetch_acc;
    logic       freeze;
    logic       if_usable;
    logic       trap;

    assign fetch_acc = inst_req & inst_addr_ok;
    assign freeze    = ((mem_st == MEM_WAIT) & ~data_data_ok) | (mm2_mem_req & ~data_addr_ok);
    assign trap      = mm1_exc | mm1_ertn;
    // Responses still owed to a squashed fetch must not be treated as a usable instruction.
    assign if_usable = if_valid & (discard_cnt == 2'd0);

    always_comb begin
        pc_wen        = 1'b0;
        wen_if_id     = 1'b0;
        wen_id_ex     = 1'b0;
        wen_ex_mm1    = 1'b0;
        wen_mm1_mm2   = 1'b0;
        wen_mm2_wb    = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mm1  = 1'b0;
        flush_mm1_mm2 = 1'b0;
        flush_mm2_wb  = 1'b0;
        redirect      = 1'b0;
        redirect_ertn = 1'b0;
        inst_discard  = 1'b0;
        if (rst_n) begin
            inst_discard = (discard_cnt != 2'd0) & inst_data_ok;
            if (!freeze) begin
                pc_wen      = 1'b1;
                wen_if_id   = 1'b1;
                wen_id_ex   = 1'b1;
                wen_ex_mm1  = 1'b1;
                wen_mm1_mm2 = 1'b1;
                wen_mm2_wb  = 1'b1;
                if (trap) begin
                    // The faulting instruction itself moves on into MM2 with its flags.
                    flush_if_id   = 1'b1;
                    flush_id_ex   = 1'b1;
                    flush_ex_mm1  = 1'b1;
                    redirect      = 1'b1;
                    redirect_ertn = mm1_ertn & ~mm1_exc;
                end else if (ex_busy) begin
                    pc_wen       = 1'b0;
                    wen_if_id    = 1'b0;
                    wen_id_ex    = 1'b0;
                    flush_ex_mm1 = 1'b1;
                end else if (id_load_use) begin
                    pc_wen      = 1'b0;
                    wen_if_id   = 1'b0;
                    flush_id_ex = 1'b1;
                end else if (!if_usable) begin
                    pc_wen      = 1'b0;
                    flush_if_id = 1'b1;
                end
            end
        end
    end

    // owed excludes any request accepted this cycle: that one targets the new PC.
    always_comb begin
        owed = if_out;
        if (inst_data_ok && (if_out != 2'd0)) owed = if_out - 2'd1;
        if_out_nxt = if_out;
        if (fetch_acc && !inst_data_ok) begin
            if (if_out < IF_MAX) if_out_nxt = if_out + 2'd1;
        end else if (!fetch_acc && inst_data_ok) begin
            if_out_nxt = owed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_st      <= RUN;
            if_out      <= 2'd0;
            discard_cnt <= 2'd0;
        end else begin
            if_out <= if_out_nxt;
            if (redirect) begin
                discard_cnt <= owed;
            end else if ((discard_cnt != 2'd0) && inst_data_ok) begin
                discard_cnt <= discard_cnt - 2'd1;
            end
            case (mem_st)
                RUN:      if (mm2_mem_req && data_addr_ok && !data_data_ok) mem_st <= MEM_WAIT;
                MEM_WAIT: if (data_data_ok) mem_st <= RUN;
                default:  mem_st <= RUN;
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic br_ex;
    logic br_lu;

    assign br_ex = ~freeze & ~trap & ex_busy;
    assign br_lu = ~freeze & ~trap & ~ex_busy & id_load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_mem_stall <= 32'd0;
            perf_ex_stall  <= 32'd0;
            perf_lu_stall  <= 32'd0;
            perf_redirect  <= 32'd0;
        end else begin
            if (freeze)   perf_mem_stall <= perf_mem_stall + 32'd1;
            if (br_ex)    perf_ex_stall  <= perf_ex_stall + 32'd1;
            if (br_lu)    perf_lu_stall  <= perf_lu_stall + 32'd1;
            if (redirect) perf_redirect  <= perf_redirect + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl against a stage-bubble reference model.
module tb_pipe_hazard_ctrl;

    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic inst_req, inst_addr_ok, inst_data_ok, if_valid, id_load_use, ex_busy;
    logic mm1_exc, mm1_ertn, mm2_mem_req, data_addr_ok, data_data_ok;
    logic pc_wen, redirect, redirect_ertn, inst_discard;
    logic wen_if_id, wen_id_ex, wen_ex_mm1, wen_mm1_mm2, wen_mm2_wb;
    logic flush_if_id, flush_id_ex, flush_ex_mm1, flush_mm1_mm2, flush_mm2_wb;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_mem_stall, perf_ex_stall, perf_lu_stall, perf_redirect;
    int m_pm, m_pe, m_pl, m_pr;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference state: outstanding fetches, responses to drop, waiting on data.
    int m_out, m_disc;
    bit m_wait;
    logic [4:0] exp_wen, exp_flush;
    logic exp_pc, exp_redir, exp_ertn, exp_disc;
    int exp_branch;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MAX_IF_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .if_valid(if_valid), .id_load_use(id_load_use), .ex_busy(ex_busy),
        .mm1_exc(mm1_exc), .mm1_ertn(mm1_ertn), .mm2_mem_req(mm2_mem_req),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .pc_wen(pc_wen),
        .wen_if_id(wen_if_id), .wen_id_ex(wen_id_ex), .wen_ex_mm1(wen_ex_mm1),
        .wen_mm1_mm2(wen_mm1_mm2), .wen_mm2_wb(wen_mm2_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mm1(flush_ex_mm1),
        .flush_mm1_mm2(flush_mm1_mm2), .flush_mm2_wb(flush_mm2_wb),
        .redirect(redirect), .redirect_ertn(redirect_ertn), .inst_discard(inst_discard)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .perf_mem_stall(perf_mem_stall), .perf_ex_stall(perf_ex_stall),
        .perf_lu_stall(perf_lu_stall), .perf_redirect(perf_redirect)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > MAXO) return MAXO;
        return v;
    endfunction

    // A stall is a bubble at register index b: registers before it hold, b gets a bubble,
    // everything after advances. Freeze holds everything, a trap flushes the front three.
    task automatic model_comb();
        int b;
        bit frz, ifv;
        exp_wen = 5'b11111; exp_flush = 5'b0; exp_pc = 1'b1;
        exp_redir = 1'b0; exp_ertn = 1'b0; exp_branch = 6;
        exp_disc = (m_disc > 0) && inst_data_ok;
        ifv = if_valid && (m_disc == 0);
        frz = (m_wait && !data_data_ok) || (mm2_mem_req && !data_addr_ok);
        b = -1;
        if (frz) begin
            exp_wen = 5'b0; exp_pc = 1'b0; exp_branch = 1;
        end else if (mm1_exc || mm1_ertn) begin
            exp_flush = 5'b00111; exp_redir = 1'b1; exp_ertn = !mm1_exc; exp_branch = 2;
        end else begin
            if (ex_busy) begin b = 2; exp_branch = 3; end
            else if (id_load_use) begin b = 1; exp_branch = 4; end
            else if (!ifv) begin b = 0; exp_branch = 5; end
            if (b >= 0) begin
                exp_pc = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    if (s < b) exp_wen[s] = 1'b0;
                    exp_flush[s] = (s == b);
                end
            end
        end
        if (!rst_n) begin
            exp_wen = 5'b0; exp_flush = 5'b0; exp_pc = 1'b0;
            exp_redir = 1'b0; exp_ertn = 1'b0; exp_disc = 1'b0; exp_branch = 0;
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_disc = 0; m_wait = 1'b0;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        m_pm = 0; m_pe = 0; m_pl = 0; m_pr = 0;
`endif
    endtask

    task automatic model_step();
        int acc, ret, owed;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = (inst_req && inst_addr_ok) ? 1 : 0;
        ret = inst_data_ok ? 1 : 0;
        owed = clamp(m_out - ret);
        m_out = clamp(m_out + acc - ret);
        if (exp_redir) m_disc = owed;
        else if (m_disc > 0 && ret == 1) m_disc--;
        if (m_wait) m_wait = !data_data_ok;
        else m_wait = mm2_mem_req && data_addr_ok && !data_data_ok;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        if (exp_branch == 1) m_pm++;
        if (exp_branch == 3) m_pe++;
        if (exp_branch == 4) m_pl++;
        if (exp_branch == 2) m_pr++;
`endif
    endtask

    task automatic compare_all();
        model_comb();
        chk("wen", {27'd0, wen_mm2_wb, wen_mm1_mm2, wen_ex_mm1, wen_id_ex, wen_if_id}, {27'd0, exp_wen});
        chk("flush", {27'd0, flush_mm2_wb, flush_mm1_mm2, flush_ex_mm1, flush_id_ex, flush_if_id},
            {27'd0, exp_flush});
        chk("pc_wen", {31'd0, pc_wen}, {31'd0, exp_pc});
        chk("redirect", {30'd0, redirect, redirect_ertn}, {30'd0, exp_redir, exp_ertn});
        chk("inst_discard", {31'd0, inst_discard}, {31'd0, exp_disc});
    endtask

    // Called right after the falling edge with inputs already set.
    task automatic cycle();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        inst_req = 0; inst_addr_ok = 0; inst_data_ok = 0; if_valid = 1; id_load_use = 0;
        ex_busy = 0; mm1_exc = 0; mm1_ertn = 0; mm2_mem_req = 0; data_addr_ok = 0; data_data_ok = 0;
    endtask

    function automatic logic pct(input int p);
        return ($urandom_range(0, 99) < p);
    endfunction

    task automatic set_random();
        inst_req = pct(60); inst_addr_ok = pct(60); inst_data_ok = pct(35);
        if_valid = pct(80); id_load_use = pct(15); ex_busy = pct(15);
        mm1_exc = pct(8); mm1_ertn = pct(6); mm2_mem_req = pct(30);
        data_addr_ok = pct(55); data_data_ok = pct(30);
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Load accepted in cycle 0, data returns in cycle 3.
        set_idle(); mm2_mem_req = 1; data_addr_ok = 1; cycle();
        set_idle(); cycle(); cycle();
        data_data_ok = 1; cycle();
        set_idle(); cycle();

        // Two fetches in flight, then an exception; three responses follow.
        inst_req = 1; inst_addr_ok = 1; cycle(); cycle();
        set_idle(); mm1_exc = 1; cycle();
        set_idle(); cycle();
        for (int k = 0; k < 3; k++) begin
            inst_data_ok = 1; cycle();
            inst_data_ok = 0; cycle();
        end

        // ertn together with ex_busy, then a 4-cycle ex_busy, then a 1-cycle load-use.
        mm1_ertn = 1; ex_busy = 1; cycle();
        mm1_ertn = 0; cycle(); cycle(); cycle(); cycle();
        ex_busy = 0; id_load_use = 1; cycle();
        id_load_use = 0; cycle();
        mm1_exc = 1; mm1_ertn = 1; cycle();
        set_idle(); cycle();

        // Asynchronous reset in the middle of a data wait.
        mm2_mem_req = 1; data_addr_ok = 1; cycle();
        set_idle(); cycle();
        #2 rst_n = 1'b0;
        #1 compare_all();
        @(posedge clk); model_step();
        @(negedge clk);
        data_data_ok = 1;
        rst_n = 1'b1;
        cycle();
        set_idle(); cycle();

        for (int i = 0; i < 2500; i++) begin
            set_random();
            if (i % 400 == 399) begin
                #2 rst_n = 1'b0;
                #1 compare_all();
                @(posedge clk); model_step();
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle();
        end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("perf_mem_stall", perf_mem_stall, 32'(m_pm));
        chk("perf_ex_stall", perf_ex_stall, 32'(m_pe));
        chk("perf_lu_stall", perf_lu_stall, 32'(m_pl));
        chk("perf_redirect", perf_redirect, 32'(m_pr));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
